// File: rtl/alu_exec_if.sv
// Bus between a requester and the alu_exec unit: request fields plus registered results.
interface alu_exec_if #(
   parameter int unsigned WIDTH = 24
);
   logic             start;
   logic [3:0]       alu_contr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             overflow;
   logic             illegal;
   logic             busy;
   logic             done;

   modport master (
      output start, alu_contr, a, b,
      input  result, result_hi, zero, overflow, illegal, busy, done
   );

   modport slave (
      input  start, alu_contr, a, b,
      output result, result_hi, zero, overflow, illegal, busy, done
   );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU with a one-cycle datapath and an optional
// iterative shift-add multiplier. Define ALU_MUL_EN to build the multiplier;
// without it, code 0100 is reported as illegal.
module alu_exec #(
   parameter int unsigned WIDTH = 24
) (
   input  logic      clk,
   input  logic      rst,
   alu_exec_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned MSB   = WIDTH - 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b0100;
`endif

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] result_q, result_nxt;
   logic [WIDTH-1:0] result_hi_q, result_hi_nxt;
   logic             zero_q, zero_nxt;
   logic             overflow_q, overflow_nxt;
   logic             illegal_q, illegal_nxt;
   logic             busy_q, done_q;

   logic [WIDTH-1:0] alu_res, sum, diff;
   logic             alu_ovf, alu_ill;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] acc, acc_nxt, acc_step;
   logic [WIDTH-1:0]   mcand, mcand_nxt, mplier, mplier_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH:0]     partial;
`endif

   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.illegal   = illegal_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // Single-cycle datapath evaluated from the live request fields.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      case (bus.alu_contr)
         OP_AND: alu_res = bus.a & bus.b;
         OP_OR:  alu_res = bus.a | bus.b;
         OP_XOR: alu_res = bus.a ^ bus.b;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
         end
         OP_SLT: alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
         OP_SLL: alu_res = (32'(bus.b[4:0]) >= WIDTH) ? '0 : (bus.a << bus.b[4:0]);
         default: alu_ill = 1'b1;
      endcase
   end

   // Next-state and next-output logic; results only change on a load.
   always_comb begin
      state_nxt     = state;
      result_nxt    = result_q;
      result_hi_nxt = result_hi_q;
      zero_nxt      = zero_q;
      overflow_nxt  = overflow_q;
      illegal_nxt   = illegal_q;
`ifdef ALU_MUL_EN
      acc_nxt    = acc;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      cnt_nxt    = cnt;
      partial    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_step   = {partial, acc[WIDTH-1:1]};
`endif
      case (state)
         S_IDLE: begin
            if (bus.start) begin
`ifdef ALU_MUL_EN
               if (bus.alu_contr == OP_MUL) begin
                  mcand_nxt  = bus.a;
                  mplier_nxt = bus.b;
                  acc_nxt    = '0;
                  cnt_nxt    = '0;
                  state_nxt  = S_MUL;
               end else
`endif
               begin
                  result_nxt    = alu_res;
                  result_hi_nxt = '0;
                  zero_nxt      = (alu_res == '0);
                  overflow_nxt  = alu_ovf;
                  illegal_nxt   = alu_ill;
                  state_nxt     = S_DONE;
               end
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            acc_nxt    = acc_step;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = CNT_W'(cnt + 1'b1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               result_nxt    = acc_step[WIDTH-1:0];
               result_hi_nxt = acc_step[2*WIDTH-1:WIDTH];
               zero_nxt      = (acc_step[WIDTH-1:0] == '0);
               overflow_nxt  = 1'b0;
               illegal_nxt   = 1'b0;
               state_nxt     = S_DONE;
            end
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef ALU_MUL_EN
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
`endif
      end else begin
         state       <= state_nxt;
         result_q    <= result_nxt;
         result_hi_q <= result_hi_nxt;
         zero_q      <= zero_nxt;
         overflow_q  <= overflow_nxt;
         illegal_q   <= illegal_nxt;
         busy_q      <= (state_nxt != S_IDLE);
         done_q      <= (state_nxt == S_DONE);
`ifdef ALU_MUL_EN
         acc         <= acc_nxt;
         mcand       <= mcand_nxt;
         mplier      <= mplier_nxt;
         cnt         <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes model predictions, a monitor
// pops them on every done pulse and checks that outputs hold otherwise.
module tb_alu_exec;

   localparam int unsigned W = 24;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         zero;
      logic         ovf;
      logic         ill;
      int           lat;
      int           issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   exp_t last;

   alu_exec_if #(.WIDTH(W)) bus ();

   alu_exec #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model from the operation definitions, using plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint m, ua, ub, sa, sb, r, full, p;
      int     sh;
      m  = longint'(1) << W;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      r  = 0;
      e.hi = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1; e.issue = 0;
      case (op)
         4'b0000: r = ua & ub;
         4'b0001: r = ua | ub;
         4'b0101: r = ua ^ ub;
         4'b0010: begin
            full = sa + sb;
            r = (ua + ub) % m;
            e.ovf = (full > m / 2 - 1) || (full < -(m / 2));
         end
         4'b1010: begin
            full = sa - sb;
            r = (ua - ub + m) % m;
            e.ovf = (full > m / 2 - 1) || (full < -(m / 2));
         end
         4'b0011: r = (sa < sb) ? 1 : 0;
         4'b0110: begin
            sh = int'(ub % 32);
            r = (sh >= int'(W)) ? 0 : ((ua << sh) % m);
         end
`ifdef ALU_MUL_EN
         4'b0100: begin
            p = ua * ub;
            r = p % m;
            e.hi = W'(p / m);
            e.lat = W + 1;
         end
`endif
         default: e.ill = 1'b1;
      endcase
      e.res  = W'(r);
      e.zero = (r == 0);
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_val();
      case ($urandom % 6)
         0: return '0;
         1: return {W{1'b1}};
         2: return {1'b0, {(W-1){1'b1}}};
         3: return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   // Issue one request, optionally poke a stray start while busy, and count busy cycles.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inj_en);
      exp_t e;
      int   n, inj;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_contr = op; bus.a = a; bus.b = b;
      e = model(op, a, b);
      e.issue = cyc + 1;
      exp_q.push_back(e);
      inj = inj_en ? int'($urandom_range(1, e.lat)) : 0;
      @(negedge clk);
      bus.start = 1'b0; bus.a = rnd_val(); bus.b = rnd_val(); bus.alu_contr = 4'($urandom);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         if (n == inj) begin
            bus.start = 1'b1; bus.alu_contr = 4'($urandom); bus.a = rnd_val(); bus.b = rnd_val();
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("busy_cycles", 64'(n), 64'(e.lat));
   endtask

   // Monitor: pop and compare on done, otherwise outputs must hold.
   initial begin
      exp_t e;
      last = '{res: '0, hi: '0, zero: 1'b0, ovf: 1'b0, ill: 1'b0, lat: 0, issue: 0};
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last = '{res: '0, hi: '0, zero: 1'b0, ovf: 1'b0, ill: 1'b0, lat: 0, issue: 0};
            continue;
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("result",    64'(bus.result),    64'(e.res));
               check("result_hi", 64'(bus.result_hi), 64'(e.hi));
               check("zero",      64'(bus.zero),      64'(e.zero));
               check("overflow",  64'(bus.overflow),  64'(e.ovf));
               check("illegal",   64'(bus.illegal),   64'(e.ill));
               check("latency",   64'(cyc - e.issue + 1), 64'(e.lat));
               last = e;
            end
         end else begin
            check("hold", 64'({bus.result, bus.result_hi, bus.zero, bus.overflow, bus.illegal}),
                  64'({last.res, last.hi, last.zero, last.ovf, last.ill}));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      logic [3:0] codes [8];
      logic [3:0] op;
      logic [W-1:0] a, b;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b1010, 4'b0011, 4'b0101, 4'b0110, 4'b0100};
      bus.start = 1'b0; bus.alu_contr = '0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", 64'({bus.result, bus.result_hi, bus.zero, bus.overflow, bus.illegal}), 64'(0));
      check("rst_busy_done", 64'({bus.busy, bus.done}), 64'(0));
      #2 rst = 1'b0;

      issue(4'b0010, 24'h7FFFFF, 24'h000001, 1'b0);
      check("add_ovf_result", 64'(bus.result), 64'(24'h800000));
      check("add_ovf_flag", 64'(bus.overflow), 64'(1));
      issue(4'b1010, 24'h000005, 24'h000005, 1'b0);
      check("sub_zero_flag", 64'(bus.zero), 64'(1));
      issue(4'b0011, 24'hFFFFFF, 24'h000001, 1'b0);
      check("slt_neg", 64'(bus.result), 64'(1));
      issue(4'b0110, 24'h000001, 24'h000017, 1'b0);
      check("sll_23", 64'(bus.result), 64'(24'h800000));
      issue(4'b0110, 24'h000001, 24'h000018, 1'b0);
      check("sll_24", 64'(bus.result), 64'(0));
      issue(4'b1111, 24'h123456, 24'h654321, 1'b0);
      check("illegal_flag", 64'({bus.illegal, bus.zero, bus.result}), 64'({1'b1, 1'b1, 24'h0}));
      issue(4'b0100, 24'h001000, 24'h001000, 1'b1);
`ifdef ALU_MUL_EN
      check("mul_hi", 64'({bus.result_hi, bus.result}), 64'({24'h000001, 24'h000000}));
`else
      check("mul_disabled", 64'({bus.illegal, bus.result}), 64'({1'b1, 24'h0}));
`endif
      issue(4'b0100, 24'h000003, 24'h000004, 1'b0);

      // Reset in the middle of a multiply, then an ADD right after release.
      @(negedge clk);
      bus.start = 1'b1; bus.alu_contr = 4'b0100; bus.a = 24'h00ABCD; bus.b = 24'h001234;
      begin
         exp_t e;
         e = model(4'b0100, 24'h00ABCD, 24'h001234);
         e.issue = cyc + 1;
         exp_q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_outputs", 64'({bus.result, bus.result_hi, bus.zero, bus.overflow, bus.illegal}), 64'(0));
      check("midrst_busy_done", 64'({bus.busy, bus.done}), 64'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      issue(4'b0010, 24'h000002, 24'h000003, 1'b0);
      check("post_rst_add", 64'(bus.result), 64'(5));

      // Randomized traffic.
      for (int i = 0; i < 250; i++) begin
         op = ($urandom % 8 == 0) ? 4'($urandom) : codes[$urandom % 8];
         a  = rnd_val();
         b  = (op == 4'b0110 && $urandom % 2 == 0) ? W'($urandom_range(0, 31)) : rnd_val();
         issue(op, a, b, ($urandom % 4) == 0);
         if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 24, operand and result width in bits.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 ALUContr  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 1010 SUB, 0011 SLT, 0101 XOR, 0110 SLL, 0100 MUL.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Result  output  WIDTH  registered result, low WIDTH bits.
REQ-009 ResultHi  output  WIDTH  registered high WIDTH bits of the MUL product; 0 for all other ops.
REQ-010 Zero  output  1  registered; 1 when Result == 0.
REQ-011 Overflow  output  1  registered signed overflow for ADD/SUB; 0 for all other ops.
REQ-012 Illegal  output  1  registered; 1 when the latched code is not in the REQ-005 list.
REQ-013 Busy  output  1  1 whenever state != IDLE.
REQ-014 Done  output  1  1 for exactly one cycle when outputs become valid.

Function
REQ-015 FSM states IDLE, MUL, DONE; Reset enters IDLE.
REQ-016 IDLE + Start + non-MUL code: compute the op from A/B/ALUContr at that edge, load the outputs, go to DONE; Done is high in the following cycle (latency 1).
REQ-017 IDLE + Start + MUL: latch A, B; clear the accumulator and counter; go to MUL.
REQ-018 MUL: one unsigned shift-add step per cycle for WIDTH cycles; counter 0..WIDTH-1; after step WIDTH-1, load Result/ResultHi with the 2*WIDTH product and go to DONE (Done high WIDTH+1 cycles after the Start edge).
REQ-019 DONE: Done=1 for one cycle, then IDLE unconditionally.
REQ-020 Start during MUL or DONE is ignored and not queued; inputs other than Start are don't-care outside the Start edge.
REQ-021 ADD/SUB: modulo 2^WIDTH. Overflow=1 when operand signs agree (ADD) or differ (SUB) and the result sign differs from A.
REQ-022 SLT: signed compare; Result = 1 if A < B, else 0.
REQ-023 SLL: A shifted left by B[4:0]; Result = 0 if B[4:0] >= WIDTH.
REQ-024 Illegal code: Result=0, ResultHi=0, Zero=1, Illegal=1; latency as REQ-016.
REQ-025 Outputs hold their last values until the next load; they do not change in IDLE.

Reset
REQ-026 Reset asserted at any time, including mid-MUL, forces IDLE; Result, ResultHi, Zero, Overflow, Illegal, Busy, Done, counter and accumulator = 0; any in-flight operation is discarded.
REQ-027 The first Start is accepted on the first rising edge after Reset deasserts.

Configuration
REQ-028 Macro ALU_MUL_EN defined: MUL behaves per REQ-017..REQ-018.
REQ-029 ALU_MUL_EN undefined: no multiplier state or logic; code 0100 is treated as illegal per REQ-024; Busy never exceeds one cycle per op.

Verification
REQ-030 Reset, then Start ADD A=0x7FFFFF, B=0x000001 -> next cycle Done=1, Result=0x800000, Overflow=1, Zero=0.
REQ-031 Start SUB A=0x000005, B=0x000005 -> Result=0, Zero=1, Overflow=0; SLT A=0xFFFFFF, B=0x000001 -> Result=1.
REQ-032 Start MUL A=0x001000, B=0x001000 -> Busy high for 25 cycles, Done exactly 25 cycles after the Start edge, Result=0x000000, ResultHi=0x000001; a second Start mid-MUL is ignored.
REQ-033 Start SLL A=0x000001, B=0x000017 -> Result=0x800000; B=0x000018 -> Result=0; code 1111 -> Illegal=1, Result=0, Zero=1.
REQ-034 Assert Reset at cycle 10 of a MUL -> all outputs 0 immediately, state IDLE; a new ADD 2+3 after release -> Result=5.
REQ-035 Build without ALU_MUL_EN: Start MUL 3*4 -> Done after 1 cycle, Illegal=1, Result=0.
